eth_gmii_rx: RTL and testbench

//  GMII receive front end; the ingress counterpart of the port's GMII transmitter.

---
 rtl/eth_gmii_rx_if.sv | 32 +++
 rtl/eth_gmii_rx.sv | 223 ++++++++++++++++++++++
 tb/tb_eth_gmii_rx.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/eth_gmii_rx_if.sv
// Signal bundle between the GMII receive front end and its PCS / FIFO neighbours.
// master = the receive block, slave = the surrounding PCS, FIFOs and statistics.
interface eth_gmii_rx_if;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;
  logic        sgmii_clk_en;
  logic        data_fifo_wr;
  logic [8:0]  data_fifo_din;
  logic        data_fifo_afull;
  logic        data_fifo_full;
  logic        cmd_fifo_wr;
  logic [71:0] cmd_fifo_din;
  logic        cmd_fifo_full;
  logic        stat_good;
  logic        stat_bad;
  logic        stat_drop;

  modport master (
    input  gmii_rxd, gmii_rx_dv, gmii_rx_er, sgmii_clk_en,
    input  data_fifo_afull, data_fifo_full, cmd_fifo_full,
    output data_fifo_wr, data_fifo_din, cmd_fifo_wr, cmd_fifo_din,
    output stat_good, stat_bad, stat_drop
  );

  modport slave (
    output gmii_rxd, gmii_rx_dv, gmii_rx_er, sgmii_clk_en,
    output data_fifo_afull, data_fifo_full, cmd_fifo_full,
    input  data_fifo_wr, data_fifo_din, cmd_fifo_wr, cmd_fifo_din,
    input  stat_good, stat_bad, stat_drop
  );
endinterface

// File: rtl/eth_gmii_rx.sv
// GMII receive front end: strips preamble/SFD, checks and strips the FCS, stores the
// frame bytes in the data FIFO and writes one 72-bit descriptor per stored frame.
//
// state   | meaning
// RX_IDLE | waiting for preamble or SFD
// RX_PRE  | inside preamble
// RX_DATA | frame body, bytes pass through a 5-byte delay line that hides the FCS
// RX_CMD  | final byte written, descriptor goes out on the next clk
// RX_DROP | frame rejected, waiting for the end of carrier
module eth_gmii_rx #(
  parameter int MAX_LEN = 1514,
  parameter int MIN_LEN = 60
) (
  input logic           clk,
  input logic           reset,
  eth_gmii_rx_if.master bus
);

  localparam logic [2:0] RX_IDLE = 3'd0;
  localparam logic [2:0] RX_PRE  = 3'd1;
  localparam logic [2:0] RX_DATA = 3'd2;
  localparam logic [2:0] RX_CMD  = 3'd3;
  localparam logic [2:0] RX_DROP = 3'd4;

  localparam logic [13:0] LEN_CAP = 14'(MAX_LEN - 1);
  localparam logic [13:0] LEN_MIN = 14'(MIN_LEN);
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  logic [7:0]  rxd_q;
  logic        dv_q, er_q, en_q;
  logic [2:0]  state_q, state_d;
  logic [39:0] dly_q, dly_d;
  logic [2:0]  held_q, held_d;
  logic [13:0] len_q, len_d;
  logic [31:0] crc_q, crc_d;
  logic        crc_err_q, crc_err_d;
  logic        len_err_q, len_err_d;
  logic        ovf_q, ovf_d;
  logic [15:0] seq_q, seq_d;
  logic        data_wr_q, data_wr_d;
  logic [8:0]  data_din_q, data_din_d;
  logic        cmd_wr_q, cmd_wr_d;
  logic [71:0] cmd_din_q, cmd_din_d;
  logic        good_q, good_d;
  logic        bad_q, bad_d;
  logic        drop_q, drop_d;
  logic        sfd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_q <= 8'd0;
      dv_q  <= 1'b0;
      er_q  <= 1'b0;
      en_q  <= 1'b0;
    end else begin
      rxd_q <= bus.gmii_rxd;
      dv_q  <= bus.gmii_rx_dv;
      er_q  <= bus.gmii_rx_er;
      en_q  <= bus.sgmii_clk_en;
    end
  end

  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    held_d     = held_q;
    len_d      = len_q;
    crc_d      = crc_q;
    crc_err_d  = crc_err_q;
    len_err_d  = len_err_q;
    ovf_d      = ovf_q;
    seq_d      = seq_q;
    data_wr_d  = 1'b0;
    data_din_d = data_din_q;
    cmd_wr_d   = 1'b0;
    cmd_din_d  = cmd_din_q;
    good_d     = 1'b0;
    bad_d      = 1'b0;
    drop_d     = 1'b0;
    sfd        = 1'b0;

    if (en_q) begin
      case (state_q)
        RX_IDLE: begin
          if (dv_q && rxd_q == 8'h55) state_d = RX_PRE;
          else if (dv_q && rxd_q == 8'hD5) sfd = 1'b1;
        end
        RX_PRE: begin
          if (!dv_q) state_d = RX_IDLE;
          else if (rxd_q == 8'hD5) sfd = 1'b1;
          else if (rxd_q != 8'h55) begin
            state_d = RX_DROP;
            drop_d  = 1'b1;
          end
        end
        RX_DATA: begin
          if (dv_q) begin
            crc_d = crc_byte(crc_q, rxd_q);
            dly_d = {dly_q[31:0], rxd_q};
            if (er_q) len_err_d = 1'b1;
            if (held_q == 3'd5) begin
              // the last stored slot is reserved for the end-of-frame write
              if (len_q == LEN_CAP) len_err_d = 1'b1;
              else begin
                len_d = len_q + 14'd1;
                if (bus.data_fifo_full) ovf_d = 1'b1;
                else begin
                  data_wr_d  = 1'b1;
                  data_din_d = {1'b0, dly_q[39:32]};
                end
              end
            end else begin
              held_d = held_q + 3'd1;
            end
          end else if (held_q != 3'd5) begin
            state_d = RX_IDLE;
            drop_d  = 1'b1;
          end else begin
            len_d     = len_q + 14'd1;
            crc_err_d = (crc_q != CRC_RESIDUE);
            if (len_q + 14'd1 < LEN_MIN) len_err_d = 1'b1;
            if (bus.data_fifo_full) ovf_d = 1'b1;
            else begin
              data_wr_d  = 1'b1;
              data_din_d = {1'b1, dly_q[39:32]};
            end
            state_d = RX_CMD;
          end
        end
        RX_DROP: begin
          if (!dv_q) state_d = RX_IDLE;
        end
        default: ;
      endcase
    end

    if (sfd) begin
      if (bus.cmd_fifo_full || bus.data_fifo_afull) begin
        state_d = RX_DROP;
        drop_d  = 1'b1;
      end else begin
        state_d   = RX_DATA;
        crc_d     = 32'hFFFFFFFF;
        held_d    = 3'd0;
        len_d     = 14'd0;
        crc_err_d = 1'b0;
        len_err_d = 1'b0;
        ovf_d     = 1'b0;
      end
    end

    // descriptor leaves one clk after the final data write, independent of the strobe
    if (state_q == RX_CMD) begin
      cmd_wr_d         = 1'b1;
      cmd_din_d        = 72'd0;
      cmd_din_d[13:0]  = len_q;
      cmd_din_d[31:16] = seq_q;
      cmd_din_d[52]    = crc_err_q;
      cmd_din_d[53]    = len_err_q;
      cmd_din_d[54]    = ovf_q;
      good_d           = !(crc_err_q || len_err_q || ovf_q);
      bad_d            = crc_err_q || len_err_q || ovf_q;
      seq_d            = seq_q + 16'd1;
      state_d          = RX_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RX_IDLE;
      dly_q      <= 40'd0;
      held_q     <= 3'd0;
      len_q      <= 14'd0;
      crc_q      <= 32'hFFFFFFFF;
      crc_err_q  <= 1'b0;
      len_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
      seq_q      <= 16'd0;
      data_wr_q  <= 1'b0;
      data_din_q <= 9'd0;
      cmd_wr_q   <= 1'b0;
      cmd_din_q  <= 72'd0;
      good_q     <= 1'b0;
      bad_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      held_q     <= held_d;
      len_q      <= len_d;
      crc_q      <= crc_d;
      crc_err_q  <= crc_err_d;
      len_err_q  <= len_err_d;
      ovf_q      <= ovf_d;
      seq_q      <= seq_d;
      data_wr_q  <= data_wr_d;
      data_din_q <= data_din_d;
      cmd_wr_q   <= cmd_wr_d;
      cmd_din_q  <= cmd_din_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.data_fifo_wr  = data_wr_q;
  assign bus.data_fifo_din = data_din_q;
  assign bus.cmd_fifo_wr   = cmd_wr_q;
  assign bus.cmd_fifo_din  = cmd_din_q;
  assign bus.stat_good     = good_q;
  assign bus.stat_bad      = bad_q;
  assign bus.stat_drop     = drop_q;

endmodule

// File: tb/tb_eth_gmii_rx.sv
// Bench for eth_gmii_rx: random frames checked against a frame-level model
// (stored bytes, descriptor fields, statistics pulses, sequence number).
module tb_eth_gmii_rx;
  logic clk;
  logic reset;
  eth_gmii_rx_if bus ();

  eth_gmii_rx dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #4 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int div     = 1;
  int exp_seq = 0;

  logic [8:0]  got_data[$];
  logic [71:0] got_cmd[$];
  int n_good, n_bad, n_drop;
  int cyc = 0;
  int prev_wr_cyc, last_data_cyc, cmd_cyc, min_gap;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (bus.data_fifo_wr) begin
        if (got_data.size() > 0 && (cyc - prev_wr_cyc) < min_gap) min_gap = cyc - prev_wr_cyc;
        prev_wr_cyc   = cyc;
        last_data_cyc = cyc;
        got_data.push_back(bus.data_fifo_din);
      end
      if (bus.cmd_fifo_wr) begin
        got_cmd.push_back(bus.cmd_fifo_din);
        cmd_cyc = cyc;
      end
      if (bus.stat_good) n_good++;
      if (bus.stat_bad)  n_bad++;
      if (bus.stat_drop) n_drop++;
    end
  end

  // one GMII byte time: strobe on the first clk, held for div clks
  task automatic gbyte(input logic [7:0] b, input logic v, input logic e);
    bus.gmii_rxd     = b;
    bus.gmii_rx_dv   = v;
    bus.gmii_rx_er   = e;
    bus.sgmii_clk_en = 1'b1;
    @(negedge clk);
    for (int k = 1; k < div; k++) begin
      bus.sgmii_clk_en = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic clear_obs();
    got_data.delete();
    got_cmd.delete();
    n_good = 0; n_bad = 0; n_drop = 0;
    min_gap = 1 << 30; last_data_cyc = 0; cmd_cyc = 0; prev_wr_cyc = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, ".dwr"},  {71'd0, bus.data_fifo_wr}, 72'd0);
    chk({tag, ".ddin"}, {63'd0, bus.data_fifo_din}, 72'd0);
    chk({tag, ".cwr"},  {71'd0, bus.cmd_fifo_wr}, 72'd0);
    chk({tag, ".cdin"}, bus.cmd_fifo_din, 72'd0);
    chk({tag, ".stat"}, {69'd0, bus.stat_good, bus.stat_bad, bus.stat_drop}, 72'd0);
  endtask

  // block: 0 none, 1 cmd_fifo_full at SFD, 2 data_fifo_afull at SFD
  task automatic run_frame(input string name, input int n, input bit corrupt,
                           input int er_pos, input int block, input bit dfull);
    logic [7:0]  pl[$];
    logic [31:0] c, fcs;
    logic [7:0]  b;
    logic [71:0] exp_desc;
    int len, bad_bytes;
    bit drop, giant, lerr, fb;

    clear_obs();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
    c = 32'hFFFFFFFF;
    foreach (pl[i]) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ pl[i][j];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    fcs = ~c;

    bus.cmd_fifo_full   = (block == 1);
    bus.data_fifo_afull = (block == 2);
    bus.data_fifo_full  = dfull;
    repeat (7) gbyte(8'h55, 1'b1, 1'b0);
    gbyte(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) gbyte(pl[i], 1'b1, (i == er_pos));
    for (int k = 0; k < 4; k++) begin
      b = fcs[8*k +: 8];
      if (corrupt && k == 1) b = b ^ 8'h10;
      gbyte(b, 1'b1, 1'b0);
    end
    repeat (12) gbyte(8'h00, 1'b0, 1'b0);
    bus.cmd_fifo_full   = 1'b0;
    bus.data_fifo_afull = 1'b0;
    bus.data_fifo_full  = 1'b0;
    repeat (4) @(negedge clk);

    drop  = (block != 0) || (n + 4 < 5);
    giant = (n > 1514);
    len   = giant ? 1514 : n;
    lerr  = (n < 60) || giant || (er_pos >= 0 && er_pos < n);

    if (drop) begin
      chk({name, ".ndata"}, got_data.size(), 0);
      chk({name, ".ncmd"},  got_cmd.size(), 0);
      chk({name, ".drop"},  n_drop, 1);
      chk({name, ".gb"},    n_good + n_bad, 0);
    end else begin
      exp_desc        = 72'd0;
      exp_desc[13:0]  = 14'(len);
      exp_desc[31:16] = 16'(exp_seq);
      exp_desc[52]    = corrupt;
      exp_desc[53]    = lerr;
      exp_desc[54]    = dfull;
      chk({name, ".ndata"}, got_data.size(), dfull ? 0 : len);
      if (!dfull && got_data.size() == len) begin
        bad_bytes = 0;
        for (int i = 0; i < len; i++) begin
          if (!(giant && i == len - 1) && got_data[i][7:0] !== pl[i]) bad_bytes++;
          if (got_data[i][8] !== (i == len - 1)) bad_bytes++;
        end
        chk({name, ".bytes"}, bad_bytes, 0);
        chk({name, ".order"}, {71'd0, cmd_cyc > last_data_cyc}, 72'd1);
        if (div > 1 && len > 1) chk({name, ".gap"}, {71'd0, min_gap >= div}, 72'd1);
      end
      chk({name, ".ncmd"}, got_cmd.size(), 1);
      if (got_cmd.size() > 0) chk({name, ".desc"}, got_cmd[0], exp_desc);
      chk({name, ".good"}, n_good, (corrupt || lerr || dfull) ? 0 : 1);
      chk({name, ".bad"},  n_bad,  (corrupt || lerr || dfull) ? 1 : 0);
      chk({name, ".drop"}, n_drop, 0);
      exp_seq++;
    end
  endtask

  initial begin
    reset               = 1'b1;
    bus.gmii_rxd        = 8'd0;
    bus.gmii_rx_dv      = 1'b0;
    bus.gmii_rx_er      = 1'b0;
    bus.sgmii_clk_en    = 1'b0;
    bus.data_fifo_afull = 1'b0;
    bus.data_fifo_full  = 1'b0;
    bus.cmd_fifo_full   = 1'b0;
    repeat (5) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    repeat (3) @(negedge clk);

    div = 1;
    run_frame("good60",   60, 1'b0, -1, 0, 1'b0);
    run_frame("badfcs",   60, 1'b1, -1, 0, 1'b0);
    run_frame("runt36",   36, 1'b0, -1, 0, 1'b0);
    run_frame("giant",  1596, 1'b0, -1, 0, 1'b0);
    run_frame("rxer",     60, 1'b0, 30, 0, 1'b0);
    run_frame("cfull",    60, 1'b0, -1, 1, 1'b0);
    run_frame("afull",    60, 1'b0, -1, 2, 1'b0);
    run_frame("after",    60, 1'b0, -1, 0, 1'b0);
    run_frame("max1514", 1514, 1'b0, -1, 0, 1'b0);
    run_frame("len59",    59, 1'b0, -1, 0, 1'b0);
    run_frame("len1",      1, 1'b0, -1, 0, 1'b0);
    run_frame("len0",      0, 1'b0, -1, 0, 1'b0);
    run_frame("ovf",      60, 1'b0, -1, 0, 1'b1);

    div = 10;
    run_frame("slow60",   60, 1'b0, -1, 0, 1'b0);

    // reset in the middle of a frame
    div = 1;
    clear_obs();
    repeat (7) gbyte(8'h55, 1'b1, 1'b0);
    gbyte(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) gbyte(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    reset          = 1'b1;
    bus.gmii_rx_dv = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("midrst");
    reset   = 1'b0;
    exp_seq = 0;
    repeat (3) @(negedge clk);
    run_frame("postrst", 60, 1'b0, -1, 0, 1'b0);

    for (int t = 0; t < 5; t++) begin
      case ($urandom_range(0, 2))
        0:       div = 1;
        1:       div = 3;
        default: div = 10;
      endcase
      run_frame($sformatf("rnd%0d", t), int'($urandom_range(40, 130)),
                ($urandom_range(0, 2) == 0), -1, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
